// File: rtl/ahb_dmem_master.sv
// ahb_dmem_master
//   Converts a simple core load/store request stream into AHB-Lite single
//   transfers using a two-register pipeline:
//     A (address phase) -> drives haddr/htrans/hsize/hwrite
//     D (data phase)    -> drives hwdata and produces the core response.
//
//   Request handshake: a request transfers on any rising clk edge where
//   req_valid && req_ready.  req_ready is combinational (slot A free or
//   being vacated this cycle).  resp_valid is a single-cycle pulse with no
//   backpressure, emitted once per accepted request, in order.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/req_ready          request handshake
//   req_addr/write/size/signed   request attributes
//   req_wdata                    store data, LSB aligned
//   resp_valid/rdata/err         response pulse, extended load data, error
//   haddr..hwrite                AHB-Lite master outputs
//   hrdata, hready, hresp        AHB-Lite master inputs
module ahb_dmem_master #(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] haddr,
  output logic [2:0]  hburst,
  output logic        hmastlock,
  output logic [3:0]  hprot,
  output logic [2:0]  hsize,
  output logic [1:0]  htrans,
  output logic [31:0] hwdata,
  output logic        hwrite,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic        hresp
);

  typedef struct packed {
    logic        valid;
    logic        mis;
    logic [31:0] addr;
    logic        write;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wdata;
  } a_t;

  typedef struct packed {
    logic        valid;
    logic        mis;
    logic        write;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  addr_lo;
    logic [31:0] wdata;
  } d_t;

  a_t a_q, a_d;
  d_t d_q, d_d;

  logic slot_free;
  logic accept;
  logic req_mis;

  // Misaligned half/word accesses and the reserved size code never reach
  // the bus; they travel through the pipeline only to produce an error.
  always_comb begin
    req_mis = 1'b0;
    case (req_size)
      2'b00:   req_mis = 1'b0;
      2'b01:   req_mis = req_addr[0];
      2'b10:   req_mis = (req_addr[1:0] != 2'b00);
      default: req_mis = 1'b1;
    endcase
  end

  assign slot_free = !a_q.valid || hready;
  assign accept    = req_valid && slot_free;

  always_comb begin
    a_d = a_q;
    d_d = d_q;
    // The bus only advances when hready is high; D simply holds otherwise.
    if (hready) begin
      d_d.valid   = a_q.valid;
      d_d.mis     = a_q.mis;
      d_d.write   = a_q.write;
      d_d.size    = a_q.size;
      d_d.sgn     = a_q.sgn;
      d_d.addr_lo = a_q.addr[1:0];
      d_d.wdata   = a_q.wdata;
    end
    if (accept) begin
      a_d.valid = 1'b1;
      a_d.mis   = req_mis;
      a_d.addr  = req_addr;
      a_d.write = req_write;
      a_d.size  = req_size;
      a_d.sgn   = req_signed;
      a_d.wdata = req_wdata;
    end else if (hready) begin
      a_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      d_q <= '0;
    end else begin
      a_q <= a_d;
      d_q <= d_d;
    end
  end

  // Address phase: purely from A so it stays stable across wait states.
  // An ERROR response does not cancel the transfer held in A.
  assign htrans    = (a_q.valid && !a_q.mis) ? 2'b10 : 2'b00;
  assign haddr     = a_q.addr;
  assign hwrite    = a_q.write;
  assign hsize     = {1'b0, a_q.size};
  assign hburst    = 3'b000;
  assign hmastlock = 1'b0;
  assign hprot     = HPROT_VAL;

  // Data phase: replicate narrow store data onto every byte lane.
  always_comb begin
    hwdata = d_q.wdata;
    case (d_q.size)
      2'b00:   hwdata = {4{d_q.wdata[7:0]}};
      2'b01:   hwdata = {2{d_q.wdata[15:0]}};
      default: hwdata = d_q.wdata;
    endcase
  end

  // Reset gates the core-side outputs immediately so a request caught in
  // flight cannot leak a response during the reset cycle.
  assign req_ready  = rst || slot_free;
  assign resp_valid = !rst && d_q.valid && hready;
  assign resp_err   = resp_valid && (d_q.mis || hresp);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  always_comb begin
    ld_byte = 8'h00;
    case (d_q.addr_lo)
      2'd0:    ld_byte = hrdata[7:0];
      2'd1:    ld_byte = hrdata[15:8];
      2'd2:    ld_byte = hrdata[23:16];
      default: ld_byte = hrdata[31:24];
    endcase
    ld_half = d_q.addr_lo[1] ? hrdata[31:16] : hrdata[15:0];
    ld_ext  = hrdata;
    case (d_q.size)
      2'b00:   ld_ext = {{24{d_q.sgn & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{d_q.sgn & ld_half[15]}}, ld_half};
      default: ld_ext = hrdata;
    endcase
  end

  assign resp_rdata = (resp_valid && !resp_err && !d_q.write) ? ld_ext : 32'h0;

endmodule

// File: tb/tb_ahb_dmem_master.sv
// tb_ahb_dmem_master
//   Directed bench for ahb_dmem_master.  Inputs change on the falling edge
//   of clk; outputs are observed 1 time unit later, well away from the
//   rising edge.  Each test task drives its scenario and checks inline.
module tb_ahb_dmem_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] haddr;
  logic [2:0]  hburst;
  logic        hmastlock;
  logic [3:0]  hprot;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic        hwrite;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  int checks = 0;
  int errors = 0;

  ahb_dmem_master #(.HPROT_VAL(4'b0011)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .haddr(haddr), .hburst(hburst), .hmastlock(hmastlock), .hprot(hprot),
    .hsize(hsize), .htrans(htrans), .hwdata(hwdata), .hwrite(hwrite),
    .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  // clock block
  always #5 clk = ~clk;

  // driver tasks
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_req(input logic v, input logic w, input logic [1:0] sz,
                           input logic sg, input logic [31:0] a, input logic [31:0] wd);
    req_valid  = v;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
  endtask

  task automatic drive_bus(input logic rdy, input logic rsp, input logic [31:0] rd);
    hready = rdy;
    hresp  = rsp;
    hrdata = rd;
  endtask

  task automatic idle_req();
    drive_req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_req();
    drive_bus(1'b1, 1'b0, 32'h0);
    next_cycle();
    next_cycle();
    settle();
    checks++; if (htrans !== 2'b00) begin errors++; $display("FAIL reset_htrans got %b exp 00", htrans); end
    checks++; if (haddr !== 32'h0) begin errors++; $display("FAIL reset_haddr got %h exp 0", haddr); end
    checks++; if (hwrite !== 1'b0 || hsize !== 3'b000) begin errors++; $display("FAIL reset_hwrite_hsize got %b %b exp 0 000", hwrite, hsize); end
    checks++; if (hwdata !== 32'h0) begin errors++; $display("FAIL reset_hwdata got %h exp 0", hwdata); end
    checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_resp got v=%b e=%b d=%h exp 0 0 0", resp_valid, resp_err, resp_rdata); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    checks++; if (hburst !== 3'b000 || hmastlock !== 1'b0 || hprot !== 4'b0011) begin
      errors++; $display("FAIL static_outputs got %b %b %b exp 000 0 0011", hburst, hmastlock, hprot); end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_store_word();
    next_cycle();
    drive_req(1'b1, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
    settle();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL sw_ready got %b exp 1", req_ready); end
    next_cycle();
    idle_req();
    settle();
    checks++; if (htrans !== 2'b10 || haddr !== 32'h100 || hsize !== 3'b010 || hwrite !== 1'b1) begin
      errors++; $display("FAIL sw_addr_phase got t=%b a=%h s=%b w=%b exp 10 100 010 1", htrans, haddr, hsize, hwrite); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL sw_early_resp got %b exp 0", resp_valid); end
    next_cycle();
    settle();
    checks++; if (hwdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_hwdata got %h exp deadbeef", hwdata); end
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
      errors++; $display("FAIL sw_resp got v=%b e=%b d=%h exp 1 0 0", resp_valid, resp_err, resp_rdata); end
    checks++; if (htrans !== 2'b00) begin errors++; $display("FAIL sw_idle_after got %b exp 00", htrans); end
    next_cycle();
    settle();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL sw_single_pulse got %b exp 0", resp_valid); end
  endtask

  // One load with zero waits; returns the response observed.
  task automatic single_load(input logic [1:0] sz, input logic sg, input logic [31:0] a,
                             input logic [31:0] rd, output logic [2:0] hs_o,
                             output logic v_o, output logic e_o, output logic [31:0] d_o);
    next_cycle();
    drive_req(1'b1, 1'b0, sz, sg, a, 32'h0);
    next_cycle();
    idle_req();
    settle();
    hs_o = hsize;
    next_cycle();
    drive_bus(1'b1, 1'b0, rd);
    settle();
    v_o = resp_valid;
    e_o = resp_err;
    d_o = resp_rdata;
    next_cycle();
    drive_bus(1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_load_extend();
    logic [2:0]  hs;
    logic        v, e;
    logic [31:0] d;
    single_load(2'b00, 1'b1, 32'h103, 32'h80FF0000, hs, v, e, d);
    checks++; if (hs !== 3'b000) begin errors++; $display("FAIL lb_hsize got %b exp 000", hs); end
    checks++; if (v !== 1'b1 || e !== 1'b0 || d !== 32'hFFFFFF80) begin
      errors++; $display("FAIL lb_signed got v=%b e=%b d=%h exp 1 0 ffffff80", v, e, d); end
    single_load(2'b00, 1'b0, 32'h103, 32'h80FF0000, hs, v, e, d);
    checks++; if (v !== 1'b1 || d !== 32'h00000080) begin
      errors++; $display("FAIL lb_unsigned got v=%b d=%h exp 1 00000080", v, d); end
    single_load(2'b00, 1'b1, 32'h102, 32'h80FF0000, hs, v, e, d);
    checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL lb_lane2 got %h exp ffffffff", d); end
    single_load(2'b01, 1'b1, 32'h202, 32'h80011234, hs, v, e, d);
    checks++; if (hs !== 3'b001 || d !== 32'hFFFF8001) begin
      errors++; $display("FAIL lh_signed got s=%b d=%h exp 001 ffff8001", hs, d); end
    single_load(2'b01, 1'b0, 32'h200, 32'h80019234, hs, v, e, d);
    checks++; if (d !== 32'h00009234) begin errors++; $display("FAIL lh_unsigned got %h exp 00009234", d); end
  endtask

  task automatic test_back_to_back();
    next_cycle();
    drive_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
    next_cycle();
    drive_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h204, 32'h0);
    settle();
    checks++; if (haddr !== 32'h200 || htrans !== 2'b10 || req_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_first_addr got a=%h t=%b r=%b exp 200 10 1", haddr, htrans, req_ready); end
    for (int w = 0; w < 2; w++) begin
      next_cycle();
      idle_req();
      drive_bus(1'b0, 1'b0, 32'h0);
      settle();
      checks++; if (haddr !== 32'h204 || htrans !== 2'b10 || req_ready !== 1'b0 || resp_valid !== 1'b0) begin
        errors++; $display("FAIL b2b_wait%0d got a=%h t=%b r=%b v=%b exp 204 10 0 0", w, haddr, htrans, req_ready, resp_valid); end
    end
    next_cycle();
    drive_bus(1'b1, 1'b0, 32'h11111111);
    settle();
    checks++; if (haddr !== 32'h204 || resp_valid !== 1'b1 || resp_rdata !== 32'h11111111 || req_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_resp0 got a=%h v=%b d=%h r=%b exp 204 1 11111111 1", haddr, resp_valid, resp_rdata, req_ready); end
    next_cycle();
    drive_bus(1'b1, 1'b0, 32'h22222222);
    settle();
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h22222222 || htrans !== 2'b00) begin
      errors++; $display("FAIL b2b_resp1 got v=%b d=%h t=%b exp 1 22222222 00", resp_valid, resp_rdata, htrans); end
    next_cycle();
    drive_bus(1'b1, 1'b0, 32'h0);
    settle();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", resp_valid); end
  endtask

  // Three loads in consecutive cycles: accept and respond overlap.
  task automatic test_throughput();
    logic [31:0] addrs [3];
    logic [31:0] datas [3];
    addrs[0] = 32'h600; addrs[1] = 32'h604; addrs[2] = 32'h608;
    datas[0] = 32'hA0A0A0A0; datas[1] = 32'hB1B1B1B1; datas[2] = 32'hC2C2C2C2;
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      if (c < 3) drive_req(1'b1, 1'b0, 2'b10, 1'b0, addrs[c], 32'h0);
      else idle_req();
      if (c >= 2) drive_bus(1'b1, 1'b0, datas[c-2]);
      settle();
      if (c < 3) begin
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL tp_ready%0d got %b exp 1", c, req_ready); end
      end
      if (c >= 1 && c <= 3) begin
        checks++; if (haddr !== addrs[c-1] || htrans !== 2'b10) begin
          errors++; $display("FAIL tp_addr%0d got %h %b exp %h 10", c, haddr, htrans, addrs[c-1]); end
      end
      if (c >= 2) begin
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== datas[c-2]) begin
          errors++; $display("FAIL tp_resp%0d got v=%b d=%h exp 1 %h", c, resp_valid, resp_rdata, datas[c-2]); end
      end
    end
    next_cycle();
    drive_bus(1'b1, 1'b0, 32'h0);
    settle();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL tp_drain got %b exp 0", resp_valid); end
  endtask

  task automatic test_narrow_store_and_misaligned();
    // half store replicated
    next_cycle();
    drive_req(1'b1, 1'b1, 2'b01, 1'b0, 32'h302, 32'h0000ABCD);
    next_cycle();
    idle_req();
    settle();
    checks++; if (htrans !== 2'b10 || hsize !== 3'b001) begin
      errors++; $display("FAIL sh_addr_phase got t=%b s=%b exp 10 001", htrans, hsize); end
    next_cycle();
    settle();
    checks++; if (hwdata !== 32'hABCDABCD || resp_valid !== 1'b1 || resp_err !== 1'b0) begin
      errors++; $display("FAIL sh_data got w=%h v=%b e=%b exp abcdabcd 1 0", hwdata, resp_valid, resp_err); end
    // byte store replicated
    next_cycle();
    drive_req(1'b1, 1'b1, 2'b00, 1'b0, 32'h101, 32'h0000005A);
    next_cycle();
    idle_req();
    next_cycle();
    settle();
    checks++; if (hwdata !== 32'h5A5A5A5A || resp_valid !== 1'b1) begin
      errors++; $display("FAIL sb_data got w=%h v=%b exp 5a5a5a5a 1", hwdata, resp_valid); end
    // misaligned half load
    next_cycle();
    drive_req(1'b1, 1'b0, 2'b01, 1'b0, 32'h301, 32'h0);
    next_cycle();
    idle_req();
    settle();
    checks++; if (htrans !== 2'b00) begin errors++; $display("FAIL mis_half_htrans got %b exp 00", htrans); end
    next_cycle();
    drive_bus(1'b1, 1'b0, 32'hFFFFFFFF);
    settle();
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
      errors++; $display("FAIL mis_half_resp got v=%b e=%b d=%h exp 1 1 0", resp_valid, resp_err, resp_rdata); end
    // misaligned word and illegal size
    next_cycle();
    drive_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0);
    next_cycle();
    drive_req(1'b1, 1'b0, 2'b11, 1'b0, 32'h100, 32'h0);
    settle();
    checks++; if (htrans !== 2'b00) begin errors++; $display("FAIL mis_word_htrans got %b exp 00", htrans); end
    next_cycle();
    idle_req();
    settle();
    checks++; if (htrans !== 2'b00 || resp_valid !== 1'b1 || resp_err !== 1'b1) begin
      errors++; $display("FAIL mis_word_resp got t=%b v=%b e=%b exp 00 1 1", htrans, resp_valid, resp_err); end
    next_cycle();
    settle();
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
      errors++; $display("FAIL illegal_size_resp got v=%b e=%b d=%h exp 1 1 0", resp_valid, resp_err, resp_rdata); end
    next_cycle();
    drive_bus(1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_error_response();
    next_cycle();
    drive_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    next_cycle();
    drive_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h404, 32'h0);
    next_cycle();
    idle_req();
    drive_bus(1'b0, 1'b1, 32'h0);
    settle();
    checks++; if (resp_valid !== 1'b0 || htrans !== 2'b10 || haddr !== 32'h404) begin
      errors++; $display("FAIL err_first got v=%b t=%b a=%h exp 0 10 404", resp_valid, htrans, haddr); end
    next_cycle();
    drive_bus(1'b1, 1'b1, 32'hDEAD0000);
    settle();
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0 || htrans !== 2'b10 || haddr !== 32'h404) begin
      errors++; $display("FAIL err_second got v=%b e=%b d=%h t=%b a=%h exp 1 1 0 10 404", resp_valid, resp_err, resp_rdata, htrans, haddr); end
    next_cycle();
    drive_bus(1'b1, 1'b0, 32'h12345678);
    settle();
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h12345678) begin
      errors++; $display("FAIL err_followup got v=%b e=%b d=%h exp 1 0 12345678", resp_valid, resp_err, resp_rdata); end
    next_cycle();
    drive_bus(1'b1, 1'b0, 32'h0);
    settle();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL err_drain got %b exp 0", resp_valid); end
  endtask

  task automatic test_reset_pending();
    next_cycle();
    drive_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h500, 32'h0);
    next_cycle();
    drive_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h504, 32'h0);
    next_cycle();
    idle_req();
    drive_bus(1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    next_cycle();
    settle();
    checks++; if (htrans !== 2'b00 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rstp_during got t=%b v=%b r=%b exp 00 0 1", htrans, resp_valid, req_ready); end
    next_cycle();
    rst = 1'b0;
    drive_bus(1'b1, 1'b0, 32'h55555555);
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++; if (resp_valid !== 1'b0 || htrans !== 2'b00) begin
        errors++; $display("FAIL rstp_stale%0d got v=%b t=%b exp 0 00", c, resp_valid, htrans); end
      next_cycle();
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_req();
    drive_bus(1'b1, 1'b0, 32'h0);
    test_reset();
    test_store_word();
    test_load_extend();
    test_back_to_back();
    test_throughput();
    test_narrow_store_and_misaligned();
    test_error_response();
    test_reset_pending();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_dmem_master.md
AHB_DMEM_MASTER -- requirements
Module: ahb_dmem_master

Interface
REQ-001 Parameter: HPROT_VAL, default 4'b0011, value driven on hprot for every transfer (non-cacheable, non-bufferable, privileged data).
REQ-002 clk  in  1  clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req_valid  in  1  core load/store request valid.
REQ-005 req_ready  out  1  request accepted on a cycle where req_valid && req_ready.
REQ-006 req_addr  in  32  byte address.
REQ-007 req_write  in  1  1 = store, 0 = load.
REQ-008 req_size  in  2  00 byte, 01 half, 10 word; 11 illegal.
REQ-009 req_signed  in  1  load sign-extends when 1, zero-extends when 0.
REQ-010 req_wdata  in  32  store data, LSB-aligned.
REQ-011 resp_valid  out  1  one-cycle response pulse; no backpressure.
REQ-012 resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-013 resp_err  out  1  bus ERROR or misaligned/illegal request.
REQ-014 AHB-Lite master outputs: haddr 32, hburst 3, hmastlock 1, hprot 4, hsize 3, htrans 2, hwdata 32, hwrite 1.
REQ-015 AHB-Lite master inputs: hrdata 32, hready 1, hresp 1.

Function
REQ-016 Two-stage pipeline: address-phase register A {valid, mis, addr, write, size, signed, wdata}; data-phase register D {valid, mis, write, size, signed, addr[1:0], wdata}.
REQ-017 All AHB address-phase outputs come from A only (never combinationally from req_*); they stay stable while hready=0.
REQ-018 htrans = 2'b10 (NONSEQ) when A.valid && !A.mis, else 2'b00 (IDLE); hburst = 3'b000; hmastlock = 0; hprot = HPROT_VAL; hsize = {1'b0, A.size}.
REQ-019 req_ready = !A.valid || hready (combinational).
REQ-020 On posedge with hready=1: D <= A; A <= accepted request if req_valid && req_ready, else A.valid <= 0.
REQ-021 On posedge with hready=0: D holds; A holds if A.valid, else A loads an accepted request.
REQ-022 Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size 11: mis=1; no bus transfer issued (htrans IDLE while in A).
REQ-023 hwdata from D: byte replicated to all 4 lanes; half replicated to both halves; word unchanged; held stable while hready=0.
REQ-024 Response: resp_valid = D.valid && hready (combinational); one pulse per accepted request, in request order.
REQ-025 resp_err = D.mis || hresp in the response cycle.
REQ-026 Load data: byte = hrdata[8*addr[1:0] +: 8]; half = hrdata[16*addr[1] +: 16]; extended to 32 bits per signed; forced 0 when resp_err=1 or the request was a store.
REQ-027 Two-cycle ERROR (hresp=1/hready=0, then hresp=1/hready=1): the transfer held in A is not cancelled; it continues normally after the error completes.
REQ-028 Latency: no wait states gives response 2 cycles after acceptance; throughput 1 request/cycle; each slave wait state adds 1 cycle.
REQ-029 Simultaneous accept and response in one cycle is legal; ordering is preserved.

Reset
REQ-030 While rst=1: A.valid=0, D.valid=0, A/D payload = 0; outputs htrans=00, haddr=0, hwrite=0, hsize=000, hwdata=0, resp_valid=0, resp_err=0, resp_rdata=0, req_ready=1.
REQ-031 Reset during a pending transfer drops it silently; no response is produced for any request accepted before reset.

Verification
REQ-032 Store word 0xDEADBEEF to 0x100, zero waits -> NONSEQ haddr=0x100 hsize=010 hwrite=1, next cycle hwdata=0xDEADBEEF, resp_valid=1 resp_err=0 resp_rdata=0.
REQ-033 Signed byte load at 0x103, hrdata=0x80FF_0000 -> hsize=000; resp_rdata=0xFFFFFF80; unsigned gives 0x00000080.
REQ-034 Back-to-back loads 0x200 and 0x204 with 2 wait states on the first -> haddr=0x204 held 3 cycles, req_ready=0 during waits, responses in order, 1 cycle apart after the waits end.
REQ-035 Half store 0xABCD at 0x302 -> hwdata=0xABCDABCD; half load at 0x301 -> no NONSEQ issued, resp_err=1, resp_rdata=0.
REQ-036 Load at 0x400 gets ERROR response while a load at 0x404 is in A -> resp_err=1 for 0x400, then 0x404 completes with resp_err=0.
REQ-037 rst asserted with a load in D and hready=0 -> next cycle htrans=00, resp_valid=0, req_ready=1; no stale response after rst deasserts.
